// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path.
package seven_seg_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_lz_mask.sv
// Leading-zero mask: flags every digit above digit 0 that lies inside the
// run of zero nibbles at the most significant end of the word.
module lz_mask
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_digits,
    input  logic                           i_lz_en,
    output logic [NUM_DIGITS-1:0]          o_supp
);

    logic w_allZero;

    // Walk from the top digit down; once a nonzero nibble is seen nothing below is suppressed.
    always_comb begin
        o_supp    = '0;
        w_allZero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_allZero = w_allZero & (i_digits[NIBBLE_W*i +: NIBBLE_W] == '0);
            o_supp[i] = i_lz_en & w_allZero & (i != 0);
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed digit scanner with per-slot blanking and leading-zero
// suppression; drives a seven_seg_decoder and a one-hot digit select.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic                           lz_en,
    output logic [NIBBLE_W-1:0]            din_out,
    output logic                           dec_en,
    output logic                           dp_out,
    output logic [NUM_DIGITS-1:0]          dig_sel,
    output logic                           frame_start
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                    r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [IDX_W-1:0]               r_idx;
    logic [NIBBLE_W*NUM_DIGITS-1:0] r_shDigits;
    logic [NUM_DIGITS-1:0]          r_shDp;
    logic                           r_shLz;

    scan_state_t                    w_stateNext;
    logic [CNT_W-1:0]               w_cntNext;
    logic [IDX_W-1:0]               w_idxNext;
    logic [NIBBLE_W*NUM_DIGITS-1:0] w_shDigitsNext;
    logic [NUM_DIGITS-1:0]          w_shDpNext;
    logic                           w_shLzNext;
    logic                           w_capture;
    logic [NUM_DIGITS-1:0]          w_suppNext;

    logic [NIBBLE_W-1:0]            w_dinNext;
    logic                           w_decEnNext;
    logic                           w_dpNext;
    logic [NUM_DIGITS-1:0]          w_digSelNext;
    logic                           w_frameStartNext;

    // The mask looks at the shadow as it will be after this edge so the
    // registered outputs line up with the state they describe.
    lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzMask (
        .i_digits (w_shDigitsNext),
        .i_lz_en  (w_shLzNext),
        .o_supp   (w_suppNext)
    );

    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_idxNext      = r_idx;
        w_capture      = 1'b0;
        if (!en) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
            w_idxNext   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_stateNext = ST_BLANK;
                    w_cntNext   = '0;
                    w_idxNext   = '0;
                    w_capture   = 1'b1;
                end
                ST_BLANK: begin
                    w_cntNext = r_cnt + CNT_W'(1);
                    if (r_cnt == BLANK_LAST) begin
                        w_stateNext = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_stateNext = ST_BLANK;
                        w_cntNext   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idxNext = '0;
                            w_capture = 1'b1;
                        end else begin
                            w_idxNext = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                    w_idxNext   = '0;
                end
            endcase
        end

        w_shDigitsNext = w_capture ? digits : r_shDigits;
        w_shDpNext     = w_capture ? dp_in  : r_shDp;
        w_shLzNext     = w_capture ? lz_en  : r_shLz;
    end

    always_comb begin
        w_dinNext        = '0;
        w_decEnNext      = 1'b0;
        w_dpNext         = 1'b0;
        w_digSelNext     = '0;
        w_frameStartNext = 1'b0;
        case (w_stateNext)
            ST_BLANK: begin
                w_dinNext        = w_shDigitsNext[NIBBLE_W*w_idxNext +: NIBBLE_W];
                w_frameStartNext = w_capture;
            end
            ST_SHOW: begin
                w_dinNext    = w_shDigitsNext[NIBBLE_W*w_idxNext +: NIBBLE_W];
                w_digSelNext = NUM_DIGITS'(1) << w_idxNext;
                w_decEnNext  = ~w_suppNext[w_idxNext];
                w_dpNext     = w_shDpNext[w_idxNext] & ~w_suppNext[w_idxNext];
            end
            default: begin
                w_dinNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shDigits  <= '0;
            r_shDp      <= '0;
            r_shLz      <= 1'b0;
            din_out     <= '0;
            dec_en      <= 1'b0;
            dp_out      <= 1'b0;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_idx       <= w_idxNext;
            r_shDigits  <= w_shDigitsNext;
            r_shDp      <= w_shDpNext;
            r_shLz      <= w_shLzNext;
            din_out     <= w_dinNext;
            dec_en      <= w_decEnNext;
            dp_out      <= w_dpNext;
            dig_sel     <= w_digSelNext;
            frame_start <= w_frameStartNext;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: checks every cycle of several frames
// against hand-chosen digit, lit and decimal-point patterns.
module tb_seven_seg_scan;

    localparam int NUM_DIGITS = 4;
    localparam int DIV        = 8;
    localparam int BLANK      = 2;
    localparam int FRAME      = NUM_DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  din_out;
    logic        dec_en;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic        frame_start;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV        (DIV),
        .BLANK      (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits      (digits),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .din_out     (din_out),
        .dec_en      (dec_en),
        .dp_out      (dp_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Output word layout: {din_out, dec_en, dp_out, dig_sel, frame_start}.
    function automatic logic [15:0] outVec();
        return {5'b0, din_out, dec_en, dp_out, dig_sel, frame_start};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        digits = d;
        dp_in  = dp;
        lz_en  = lz;
    endtask

    task automatic checkFrame(input int frameId, input logic [15:0] expDigits,
                              input logic [3:0] litMask, input logic [3:0] dpMask,
                              input int changeCycle, input logic [15:0] newDigits,
                              input logic [3:0] newDp, input logic newLz);
        logic [15:0] expVec;
        logic [3:0]  nib;
        int          slot;
        int          pos;
        for (int c = 0; c < FRAME; c++) begin
            slot = c / DIV;
            pos  = c % DIV;
            nib  = expDigits[4*slot +: 4];
            if (pos < BLANK)
                expVec = {5'b0, nib, 1'b0, 1'b0, 4'b0000, (c == 0)};
            else
                expVec = {5'b0, nib, litMask[slot], dpMask[slot], 4'(1 << slot), 1'b0};
            checkOutput($sformatf("frame%0d cyc%0d", frameId, c), outVec(), expVec);
            if (c == changeCycle)
                applyStimulus(newDigits, newDp, newLz);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        applyStimulus(16'h4321, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("reset%0d", i), outVec(), 16'h0000);
        end
        rst = 1'b0;
        step();

        checkFrame(1, 16'h4321, 4'b1111, 4'b0000, 10, 16'h1111, 4'b0000, 1'b0);
        checkFrame(2, 16'h1111, 4'b1111, 4'b0000, 12, 16'h2222, 4'b0000, 1'b0);
        checkFrame(3, 16'h2222, 4'b1111, 4'b0000, 5,  16'h0050, 4'b0000, 1'b1);
        checkFrame(4, 16'h0050, 4'b0011, 4'b0000, 5,  16'h0000, 4'b0000, 1'b1);
        checkFrame(5, 16'h0000, 4'b0001, 4'b0000, 5,  16'h1234, 4'b0100, 1'b0);
        checkFrame(6, 16'h1234, 4'b1111, 4'b0100, 5,  16'h0034, 4'b0100, 1'b1);
        checkFrame(7, 16'h0034, 4'b0011, 4'b0000, 5,  16'h4321, 4'b0000, 1'b0);

        // Drop enable in the middle of digit 2's show phase.
        for (int i = 0; i < 2 * DIV + BLANK + 1; i++)
            step();
        checkOutput("dropPre", outVec(), {5'b0, 4'h3, 1'b1, 1'b0, 4'b0100, 1'b0});
        en = 1'b0;
        step();
        checkOutput("dropEdge", outVec(), 16'h0000);
        step();
        checkOutput("dropHold", outVec(), 16'h0000);
        en = 1'b1;
        step();
        checkFrame(8, 16'h4321, 4'b1111, 4'b0000, -1, 16'h4321, 4'b0000, 1'b0);
        checkOutput("nextFrameStart", outVec(), {5'b0, 4'h1, 1'b0, 1'b0, 4'b0000, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
